// File: rtl/mem_arbiter.sv
// Byte-serialising memory port controller: round-robin arbitration between ICache
// word fetches and LSB loads/stores, with misprediction flush and IO write stalls.
module mem_arbiter #(
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong,
    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    output logic        icache_valid,
    output logic [31:0] icache_instr,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_valid,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] base_q, base_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] wdata_q, wdata_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        icache_valid_q, icache_valid_d;
    logic [31:0] icache_instr_q, icache_instr_d;
    logic        lsb_valid_q, lsb_valid_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        ic_go, lsb_go, grant_lsb;
    logic [1:0]  rd_idx;
    logic        io_stall;

    assign rd_idx   = cnt_q[1:0] - 2'd1;
    assign io_stall = (base_q[17:16] == IO_BASE_HI) && io_buffer_full;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        n_d            = n_q;
        base_d         = base_q;
        buf_d          = buf_q;
        wdata_d        = wdata_q;
        last_grant_d   = last_grant_q;
        mem_a_d        = mem_a_q;
        mem_dout_d     = mem_dout_q;
        mem_wr_d       = 1'b0;
        icache_valid_d = 1'b0;
        icache_instr_d = icache_instr_q;
        lsb_valid_d    = 1'b0;
        lsb_rdata_d    = lsb_rdata_q;

        // A requester's req is still high in its own valid cycle; that is not a new request.
        ic_go     = icache_req && !icache_valid_q;
        lsb_go    = lsb_req && !lsb_valid_q;
        grant_lsb = lsb_go && (!ic_go || !last_grant_q);

        case (state_q)
            IDLE: begin
                if (!jump_wrong && (ic_go || lsb_go)) begin
                    cnt_d        = 3'd0;
                    buf_d        = 32'd0;
                    last_grant_d = grant_lsb;
                    if (grant_lsb) begin
                        base_d  = lsb_addr;
                        n_d     = {1'b0, lsb_len} + 3'd1;
                        wdata_d = lsb_wdata;
                        state_d = lsb_wr ? STORE : LOAD;
                    end else begin
                        base_d  = icache_addr;
                        n_d     = 3'd4;
                        state_d = IFETCH;
                    end
                end
            end

            IFETCH, LOAD: begin
                if (jump_wrong) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q < n_q)
                        mem_a_d = base_q + {29'd0, cnt_q};
                    // mem_din answers the address issued on the previous edge.
                    if (cnt_q != 3'd0)
                        buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
                    if (cnt_q == n_q) begin
                        state_d = IDLE;
                        if (state_q == IFETCH) begin
                            icache_valid_d = 1'b1;
                            icache_instr_d = buf_d;
                        end else begin
                            lsb_valid_d = 1'b1;
                            lsb_rdata_d = buf_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            STORE: begin
                if (!io_stall) begin
                    mem_a_d    = base_q + {29'd0, cnt_q};
                    mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    mem_wr_d   = 1'b1;
                    if (cnt_q == n_q - 3'd1) begin
                        lsb_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            n_q            <= 3'd0;
            base_q         <= 32'd0;
            buf_q          <= 32'd0;
            wdata_q        <= 32'd0;
            last_grant_q   <= 1'b0;
            mem_a_q        <= 32'd0;
            mem_dout_q     <= 8'd0;
            mem_wr_q       <= 1'b0;
            icache_valid_q <= 1'b0;
            icache_instr_q <= 32'd0;
            lsb_valid_q    <= 1'b0;
            lsb_rdata_q    <= 32'd0;
        end else if (rdy) begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            n_q            <= n_d;
            base_q         <= base_d;
            buf_q          <= buf_d;
            wdata_q        <= wdata_d;
            last_grant_q   <= last_grant_d;
            mem_a_q        <= mem_a_d;
            mem_dout_q     <= mem_dout_d;
            mem_wr_q       <= mem_wr_d;
            icache_valid_q <= icache_valid_d;
            icache_instr_q <= icache_instr_d;
            lsb_valid_q    <= lsb_valid_d;
            lsb_rdata_q    <= lsb_rdata_d;
        end
    end

    // A held write strobe must not repeat the byte while the block is frozen.
    assign mem_wr       = mem_wr_q & rdy;
    assign mem_a        = mem_a_q;
    assign mem_dout     = mem_dout_q;
    assign icache_valid = icache_valid_q;
    assign icache_instr = icache_instr_q;
    assign lsb_valid    = lsb_valid_q;
    assign lsb_rdata    = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transfers plus hand-written
// sequences for flush, IO stall, rdy freeze, reset mid-transfer and contention.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_wrong;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_instr;
    logic        lsb_req, lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr, lsb_wdata;
    logic        lsb_valid;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    always #5 clk = ~clk;

    mem_arbiter #(.IO_BASE_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_valid(icache_valid), .icache_instr(icache_instr),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_valid(lsb_valid), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    // RAM model: read byte for the address presented this cycle, write on the edge.
    logic [7:0]  ram [0:4095];
    logic        ram_init;
    int          io_cnt = 0;
    logic [7:0]  io_last = 8'h00;
    logic [31:0] io_addr = 32'h0;

    assign mem_din = ram[mem_a[11:0]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h13;
            ram[12'h101] <= 8'h05;
            ram[12'h302] <= 8'h33;
            ram[12'h303] <= 8'h44;
        end else if (mem_wr && mem_a[17:16] != 2'b11) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
        if (mem_wr && mem_a[17:16] == 2'b11) begin
            io_cnt  <= io_cnt + 1;
            io_last <= mem_dout;
            io_addr <= mem_a;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer. Latency = index of the edge after E0 whose output shows valid.
    // nstall: io_buffer_full seen at E1..E(nstall); jw_edge: jump_wrong seen at that edge.
    task automatic xfer(input logic is_lsb, input logic wr, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int nstall, input int jw_edge,
                        output int lat, output logic [31:0] data,
                        output int wrs, output logic stuck);
        lat = -1; data = 32'h0; wrs = 0; stuck = 1'b0;
        if (is_lsb) begin
            lsb_req = 1'b1; lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_wdata = wdata;
        end else begin
            icache_req = 1'b1; icache_addr = addr;
        end
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (mem_wr) wrs++;
            io_buffer_full = (k < nstall);
            jump_wrong     = (k + 1 == jw_edge);
            if (jw_edge > 0 && k >= jw_edge && !wr) begin
                icache_req = 1'b0;
                lsb_req    = 1'b0;
            end
            if (is_lsb ? lsb_valid : icache_valid) begin
                lat  = k;
                data = is_lsb ? lsb_rdata : icache_instr;
                break;
            end
        end
        icache_req = 1'b0; lsb_req = 1'b0; io_buffer_full = 1'b0; jump_wrong = 1'b0;
        if (lat >= 0) begin
            tick();
            stuck = is_lsb ? lsb_valid : icache_valid;
        end
    endtask

    typedef struct {
        string       name;
        logic        is_lsb;
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_data;
        int          exp_wrs;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat, wrs, seen, n_seen, io_before;
        logic [31:0] data;
        logic        stuck;
        logic [3:0]  order;

        rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0; io_buffer_full = 1'b0;
        icache_req = 1'b0; icache_addr = 32'h0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h0; lsb_wdata = 32'h0;
        ram_init = 1'b1;

        vecs[0] = '{"fetch_100",    1'b0, 1'b0, 2'd0, 32'h100, 32'h0,        5, 32'h00000513, 0};
        vecs[1] = '{"st_word_200",  1'b1, 1'b1, 2'd3, 32'h200, 32'hDEADBEEF, 4, 32'h0,        4};
        vecs[2] = '{"ld_byte_201",  1'b1, 1'b0, 2'd0, 32'h201, 32'h0,        2, 32'h000000BE, 0};
        vecs[3] = '{"ld_half_202",  1'b1, 1'b0, 2'd1, 32'h202, 32'h0,        3, 32'h0000DEAD, 0};
        vecs[4] = '{"ld_word_200",  1'b1, 1'b0, 2'd3, 32'h200, 32'h0,        5, 32'hDEADBEEF, 0};
        vecs[5] = '{"st_half_300",  1'b1, 1'b1, 2'd1, 32'h300, 32'h00001234, 2, 32'h0,        2};
        vecs[6] = '{"ld_word_300",  1'b1, 1'b0, 2'd3, 32'h300, 32'h0,        5, 32'h44331234, 0};
        vecs[7] = '{"fetch_300",    1'b0, 1'b0, 2'd0, 32'h300, 32'h0,        5, 32'h44331234, 0};
        vecs[8] = '{"st_byte_303",  1'b1, 1'b1, 2'd0, 32'h303, 32'hAABBCC77, 1, 32'h0,        1};
        vecs[9] = '{"ld_word_300b", 1'b1, 1'b0, 2'd3, 32'h300, 32'h0,        5, 32'h77331234, 0};

        #1;
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_ctl", 32'({mem_wr, icache_valid, lsb_valid, mem_dout}), 32'h0);
        tick();
        ram_init = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("idle_quiet", 32'({mem_wr, icache_valid, lsb_valid}), 32'h0);
        check("idle_data", icache_instr | lsb_rdata, 32'h0);

        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].is_lsb, vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata,
                 0, 0, lat, data, wrs, stuck);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            if (!vecs[i].wr) check({vecs[i].name, "_data"}, data, vecs[i].exp_data);
            check({vecs[i].name, "_wrs"}, 32'(wrs), 32'(vecs[i].exp_wrs));
            check({vecs[i].name, "_pulse"}, 32'(stuck), 32'h0);
        end

        // Flush at E2 of a fetch: no valid, block back in IDLE.
        xfer(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, 0, 2, lat, data, wrs, stuck);
        check("flush_no_valid", 32'(lat), 32'hFFFF_FFFF);
        xfer(1'b1, 1'b0, 2'd0, 32'h201, 32'h0, 0, 0, lat, data, wrs, stuck);
        check("post_flush_lat", 32'(lat), 32'd2);
        check("post_flush_data", data, 32'h000000BE);

        // Flush during a store is ignored.
        xfer(1'b1, 1'b1, 2'd3, 32'h210, 32'hCAFEF00D, 0, 2, lat, data, wrs, stuck);
        check("st_flush_lat", 32'(lat), 32'd4);
        check("st_flush_wrs", 32'(wrs), 32'd4);
        xfer(1'b1, 1'b0, 2'd3, 32'h210, 32'h0, 0, 0, lat, data, wrs, stuck);
        check("st_flush_data", data, 32'hCAFEF00D);

        // IO stall for three edges on a byte store.
        io_before = io_cnt;
        xfer(1'b1, 1'b1, 2'd0, 32'h30000, 32'h41, 3, 0, lat, data, wrs, stuck);
        check("io_stall_lat", 32'(lat), 32'd4);
        check("io_stall_wrs", 32'(wrs), 32'd1);
        check("io_stall_cnt", 32'(io_cnt - io_before), 32'd1);
        check("io_stall_byte", 32'(io_last), 32'h41);
        check("io_stall_addr", io_addr, 32'h30000);
        xfer(1'b1, 1'b1, 2'd0, 32'h30001, 32'h42, 0, 0, lat, data, wrs, stuck);
        check("io_nostall_lat", 32'(lat), 32'd1);

        // rdy low in the middle of a word store.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd3; lsb_addr = 32'h220; lsb_wdata = 32'h89ABCDEF;
        tick(); tick(); tick();
        check("pre_freeze_wr", 32'(mem_wr), 32'h1);
        rdy = 1'b0;
        #1;
        check("rdy_gate_wr", 32'(mem_wr), 32'h0);
        seen = 0;
        repeat (3) begin
            tick();
            if (mem_wr || lsb_valid) seen++;
        end
        check("frozen_quiet", 32'(seen), 32'h0);
        rdy = 1'b1;
        #1;
        check("resume_wr", 32'(mem_wr), 32'h1);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (lsb_valid) begin
                lat = k;
                break;
            end
        end
        lsb_req = 1'b0;
        check("resume_lat", 32'(lat), 32'd2);
        tick();
        xfer(1'b1, 1'b0, 2'd3, 32'h220, 32'h0, 0, 0, lat, data, wrs, stuck);
        check("resume_data", data, 32'h89ABCDEF);

        // Reset in the middle of a word load.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd3; lsb_addr = 32'h300;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        check("midrst_mem_a", mem_a, 32'h0);
        check("midrst_ctl", 32'({mem_wr, icache_valid, lsb_valid, mem_dout}), 32'h0);
        check("midrst_instr", icache_instr, 32'h0);
        check("midrst_rdata", lsb_rdata, 32'h0);
        lsb_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (lsb_valid || icache_valid) seen++;
        end
        check("midrst_no_valid", 32'(seen), 32'h0);

        // Contention from reset: LSB, ICache, LSB, ICache.
        rst = 1'b0;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h201;
        icache_req = 1'b1; icache_addr = 32'h100;
        tick();
        rst = 1'b1;
        order = 4'h0; n_seen = 0; seen = 0;
        for (int k = 0; k < 40 && n_seen < 4; k++) begin
            tick();
            if (lsb_valid && icache_valid) seen++;
            else if (lsb_valid || icache_valid) begin
                order = {order[2:0], lsb_valid};
                n_seen++;
            end
        end
        lsb_req = 1'b0; icache_req = 1'b0;
        check("rr_count", 32'(n_seen), 32'd4);
        check("rr_order", 32'(order), 32'b1010);
        check("rr_no_overlap", 32'(seen), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
